pdm_demod: RTL and testbench

- Receive-side counterpart of the team's first-order PDM modulator: converts a 1-bit PDM stream back into 16-bit unsigned density words, on the same scale as the modulator's duty input (0x0000 means all zeros, 0xFFFF means all ones).
- Used as the mic/loopback front end and as a self-check on modulator output.
- Architecture: 2-flop synchronizer, then a 3rd-order CIC decimator (integrators, decimate by R, combs), then a valid/ready output register with sticky overrun.

---
 rtl/pdm_pkg.sv | 16 +
 rtl/pdm_demod_sync.sv | 23 ++
 rtl/pdm_demod.sv | 118 +++++++++++
 tb/tb_pdm_demod.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pdm_pkg.sv
// pdm_pkg: constants shared by the PDM modulator and demodulator.
//   CIC_ORDER  : order of the demodulator's CIC decimator
//   PCM_W      : width of density/PCM words (also the modulator's duty width)
//   PCM_SAT    : full-scale saturation value for PCM words
//   cic_width(): CIC accumulator width for a given log2 decimation ratio
package pdm_pkg;
  localparam int CIC_ORDER = 3;
  localparam int PCM_W     = 16;
  localparam logic [PCM_W-1:0] PCM_SAT = 16'hFFFF;

  // Register growth of an N-stage CIC is N*log2(R); one extra bit lets
  // the full-scale value R^N itself be represented.
  function automatic int cic_width(input int log2r);
    return CIC_ORDER * log2r + 1;
  endfunction
endpackage

// File: rtl/pdm_demod_sync.sv
// pdm_sync: 2-flop synchronizer for an asynchronous 1-bit input.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset (flops clear to 0)
//   d     : asynchronous input
//   q     : synchronized output (2 clk edges of latency)
module pdm_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end
endmodule

// File: rtl/pdm_demod.sv
// pdm_demod: 1-bit PDM stream -> 16-bit unsigned density words.
// Synchronizer, 3rd-order CIC decimator (R = 2^LOG2_DECIM), then a
// valid/ready output register with sticky overrun.
//   clk, rst_n : clock, asynchronous active-low reset
//   pdm_in     : raw PDM pin (asynchronous)
//   smpl_en    : one-cycle strobe per PDM bit period
//   pcm        : demodulated density (0x0000 all zeros .. 0xFFFF all ones)
//   pcm_vld    : pcm holds an unconsumed sample
//   pcm_rdy    : consumer accepts pcm when pcm_vld && pcm_rdy
//   ovr        : sticky overrun (sample overwritten before acceptance)
//   clr_ovr    : synchronous clear of ovr (a coincident new overrun wins)
// Build option: define PDM_DEMOD_WARMUP_EN to suppress the first three
// (settling) decimated outputs after reset.
module pdm_demod
  import pdm_pkg::*;
#(
  parameter int LOG2_DECIM = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pdm_in,
  input  logic             smpl_en,
  output logic [PCM_W-1:0] pcm,
  output logic             pcm_vld,
  input  logic             pcm_rdy,
  output logic             ovr,
  input  logic             clr_ovr
);
  localparam int W     = cic_width(LOG2_DECIM);
  localparam int SHIFT = PCM_W - CIC_ORDER * LOG2_DECIM;
  localparam int SW    = PCM_W + 1;

  logic s2;
  pdm_sync u_sync (.clk(clk), .rst_n(rst_n), .d(pdm_in), .q(s2));

  logic [W-1:0] x, i1, i2, i3, i1_n, i2_n, i3_n;
  logic [W-1:0] d1, d2, d3, c1, c2, c3;
  logic [LOG2_DECIM-1:0] cnt;
  logic [SW-1:0] scaled;
  logic [PCM_W-1:0] pcm_new, pcm_new_q;
  logic dec_q, cmb_vld;

  assign x = W'(s2);

  // Integrators chain within one cycle; modulo-2^W wrap is cancelled by
  // the combs, so no saturation here.
  always_comb begin
    i1_n = i1 + x;
    i2_n = i2 + i1_n;
    i3_n = i3 + i2_n;
    c1   = i3 - d1;
    c2   = c1 - d2;
    c3   = c2 - d3;
  end

  // Full-scale C3 is exactly R^3, which lands one past 16 bits after the
  // shift; clamp it to the top code.
  assign scaled  = SW'(c3) << SHIFT;
  assign pcm_new = scaled[PCM_W] ? PCM_SAT : scaled[PCM_W-1:0];

`ifdef PDM_DEMOD_WARMUP_EN
  logic [1:0] wu;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i1 <= '0; i2 <= '0; i3 <= '0;
      d1 <= '0; d2 <= '0; d3 <= '0;
      cnt       <= '0;
      dec_q     <= 1'b0;
      cmb_vld   <= 1'b0;
      pcm_new_q <= '0;
`ifdef PDM_DEMOD_WARMUP_EN
      wu        <= 2'd0;
`endif
    end else begin
      if (smpl_en) begin
        i1  <= i1_n;
        i2  <= i2_n;
        i3  <= i3_n;
        cnt <= cnt + 1'b1;
      end
      // Flags the edge after the decimating strobe, when i3 is updated.
      dec_q <= smpl_en && (cnt == '1);
      if (dec_q) begin
        d1        <= i3;
        d2        <= c1;
        d3        <= c2;
        pcm_new_q <= pcm_new;
      end
`ifdef PDM_DEMOD_WARMUP_EN
      // Combs keep running during warm-up; only presentation is held off.
      if (dec_q && wu != 2'd3) wu <= wu + 2'd1;
      cmb_vld <= dec_q && (wu == 2'd3);
`else
      cmb_vld <= dec_q;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcm     <= '0;
      pcm_vld <= 1'b0;
      ovr     <= 1'b0;
    end else begin
      if (cmb_vld) begin
        pcm     <= pcm_new_q;
        pcm_vld <= 1'b1;
      end else if (pcm_rdy) begin
        pcm_vld <= 1'b0;
      end
      // An accept in the same cycle as a load is not an overrun.
      if (cmb_vld && pcm_vld && !pcm_rdy) ovr <= 1'b1;
      else if (clr_ovr)                   ovr <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pdm_demod.sv
// tb_pdm_demod: directed bench for pdm_demod (LOG2_DECIM=5). A reference
// model computes each decimated output by direct convolution with the
// CIC impulse response and queues it with its due cycle; the queue is
// popped into a model output register when the sample should appear.
module tb_pdm_demod;
  localparam int L  = 5;
  localparam int R  = 1 << L;
  localparam int NT = 3 * R - 2;

  logic clk = 1'b0, rst_n = 1'b0, smpl_en = 1'b0, pcm_rdy = 1'b1, clr_ovr = 1'b0;
  logic pdm_drv = 1'b0, mod_en = 1'b0, mod_bit = 1'b0;
  logic [15:0] mod_acc = 16'h0;
  logic pdm_in;
  logic [15:0] pcm;
  logic pcm_vld, ovr;

  assign pdm_in = mod_en ? mod_bit : pdm_drv;

  pdm_demod #(.LOG2_DECIM(L)) dut (
    .clk(clk), .rst_n(rst_n), .pdm_in(pdm_in), .smpl_en(smpl_en),
    .pcm(pcm), .pcm_vld(pcm_vld), .pcm_rdy(pcm_rdy),
    .ovr(ovr), .clr_ovr(clr_ovr)
  );

  always #5 clk = ~clk;

  // First-order modulator for loopback, duty 0x4000.
  always @(negedge clk)
    if (mod_en) {mod_bit, mod_acc} <= {1'b0, mod_acc} + 17'h04000;

  typedef struct { logic [15:0] v; int due; } exp_t;
  exp_t sb[$];
  bit hist[$];
  int h[NT];
  int cyc = 0, mcnt = 0;
  logic s1m = 1'b0, s2m = 1'b0, mvld = 1'b0, movr = 1'b0;
  logic [15:0] mpcm = 16'h0;
`ifdef PDM_DEMOD_WARMUP_EN
  int ndec = 0;
`endif

  always @(posedge clk or negedge rst_n) begin : model
    int now, n, y;
    exp_t e;
    if (!rst_n) begin
      s1m <= 1'b0; s2m <= 1'b0; mcnt <= 0; cyc <= 0;
      mvld <= 1'b0; movr <= 1'b0; mpcm <= 16'h0;
      hist.delete(); sb.delete();
`ifdef PDM_DEMOD_WARMUP_EN
      ndec <= 0;
`endif
    end else begin
      now = cyc + 1;
      cyc <= now;
      s1m <= pdm_in;
      s2m <= s1m;
      if (smpl_en) begin
        hist.push_back(s2m);
        if (mcnt == R - 1) begin
          mcnt <= 0;
          n = hist.size() - 1;
          y = 0;
          for (int k = 0; k < NT; k++)
            if (n - k >= 0) y += h[k] * int'(hist[n-k]);
          y = y << (16 - 3 * L);
          if (y > 65535) y = 65535;
          e.v = 16'(y);
          e.due = now + 2;
`ifdef PDM_DEMOD_WARMUP_EN
          if (ndec < 3) ndec <= ndec + 1;
          else sb.push_back(e);
`else
          sb.push_back(e);
`endif
        end else begin
          mcnt <= mcnt + 1;
        end
      end
      if (sb.size() > 0 && sb[0].due == now) begin
        mpcm <= sb[0].v;
        mvld <= 1'b1;
        if (mvld && !pcm_rdy) movr <= 1'b1;
        else if (clr_ovr)     movr <= 1'b0;
        void'(sb.pop_front());
      end else begin
        if (pcm_rdy) mvld <= 1'b0;
        if (clr_ovr) movr <= 1'b0;
      end
    end
  end

  int nerr = 0, nchk = 0, vld_seen = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the next negedge and compare the DUT against the model.
  task automatic tick();
    @(negedge clk);
    if (chk_en) begin
      chk("vld", {15'b0, pcm_vld}, {15'b0, mvld});
      chk("ovr", {15'b0, ovr}, {15'b0, movr});
      chk("pcm", pcm, mpcm);
    end
    if (pcm_vld) vld_seen++;
  endtask

  // mode 0: constant 0, 1: constant 1, 2: alternating per strobe.
  task automatic strobes(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      tick();
      smpl_en = 1'b1;
      pdm_drv = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : ~pdm_drv;
      tick();
      smpl_en = 1'b0;
      tick();
      tick();
    end
  endtask

  initial begin
    for (int k = 0; k < NT; k++) h[k] = 0;
    for (int a = 0; a < R; a++)
      for (int b = 0; b < R; b++)
        for (int c = 0; c < R; c++)
          h[a+b+c]++;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_pcm", pcm, 16'h0000);
    chk("rst_vld", {15'b0, pcm_vld}, 16'h0);
    chk("rst_ovr", {15'b0, ovr}, 16'h0);
    chk_en = 1'b1;

    strobes(4 * R, 0);
    chk("zero_pcm", pcm, 16'h0000);
    chk("zero_ovr", {15'b0, ovr}, 16'h0);

    strobes(5 * R, 1);
    chk("ones_pcm", pcm, 16'hFFFF);

    strobes(4 * R, 2);
    vld_seen = 0;
    strobes(2 * R, 2);
    chk("alt_pulses", 16'(vld_seen), 16'd2);
    chk("alt_pcm", pcm, 16'h8000);

    // Two outputs while stalled: overrun, second sample kept.
    pcm_rdy = 1'b0;
    strobes(2 * R, 2);
    chk("ovr_set", {15'b0, ovr}, 16'h1);
    chk("ovr_pcm", pcm, 16'h8000);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    tick();
    chk("ovr_clr", {15'b0, ovr}, 16'h0);
    pcm_rdy = 1'b1;
    tick();
    chk("vld_drop", {15'b0, pcm_vld}, 16'h0);

    // clr_ovr held through a new overrun: set wins on that edge.
    pcm_rdy = 1'b0;
    clr_ovr = 1'b1;
    strobes(2 * R, 2);
    clr_ovr = 1'b0;
    pcm_rdy = 1'b1;
    tick();

    // Loopback from the modulator at full clk rate.
    mod_en = 1'b1;
    smpl_en = 1'b1;
    repeat (6 * R) tick();
    smpl_en = 1'b0;
    mod_en = 1'b0;
    chk("lb_range", {15'b0, (pcm >= 16'h3F00) && (pcm <= 16'h4100)}, 16'h1);
    repeat (4) tick();

    // Mid-window reset with a held sample.
    pcm_rdy = 1'b0;
    strobes(R + 8, 1);
    for (int i = 0; i < R && mcnt != 17; i++) strobes(1, 1);
    chk("at_strobe17", 16'(mcnt), 16'd17);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pcm", pcm, 16'h0000);
    chk("mid_rst_vld", {15'b0, pcm_vld}, 16'h0);
    chk("mid_rst_ovr", {15'b0, ovr}, 16'h0);
    tick();
    tick();
    rst_n = 1'b1;
    pcm_rdy = 1'b1;
    vld_seen = 0;
`ifdef PDM_DEMOD_WARMUP_EN
    strobes(4 * R - 1, 1);
`else
    strobes(R - 1, 1);
`endif
    chk("no_early_vld", 16'(vld_seen), 16'd0);
    strobes(1, 1);
    chk("first_vld", {15'b0, vld_seen != 0}, 16'h1);
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
